// File: rtl/instr_pkg.sv
// Shared constants and state type for the instruction realignment block.
package instr_pkg;

    // Default slot count and data width
    localparam int unsigned NUM_INSTR_DEFAULT     = 4;
    localparam int unsigned NUM_DATA_BITS_DEFAULT = 64;

    // IDLE passes a cycle straight through; HOLD waits for the second half of a split set
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/count_ones.sv
// Combinational population count of a bit vector.
module count_ones #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     bits,
    output logic [CNT_WIDTH-1:0] ones
);

    // Sum every set bit
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CNT_WIDTH'(bits[i]);
        end
    end

endmodule

// File: rtl/instr_realign.sv
// Rebuilds an instruction set that the delaying side may split over two cycles,
// presenting it (with its issue-cycle data) as one registered aligned output.
module instr_realign
    import instr_pkg::*;
#(
    parameter int unsigned NUM_INSTR     = NUM_INSTR_DEFAULT,
    parameter int unsigned NUM_DATA_BITS = NUM_DATA_BITS_DEFAULT,
    parameter int unsigned CNTWIDTH      = $clog2(NUM_INSTR + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_INSTR-1:0]     orig_instructions,
    input  logic [NUM_INSTR-1:0]     delayed_instructions,
    input  logic [NUM_DATA_BITS-1:0] data_in,
    output logic                     aligned_valid,
    output logic [NUM_INSTR-1:0]     aligned_instructions,
    output logic [NUM_DATA_BITS-1:0] data_out,
    output logic [CNTWIDTH-1:0]      count,
    output logic                     error
);

    state_t                   state_q, state_d;
    logic [NUM_INSTR-1:0]     cap_instr_q, cap_instr_d;
    logic [NUM_INSTR-1:0]     cap_part_q, cap_part_d;
    logic [NUM_DATA_BITS-1:0] cap_data_q, cap_data_d;
    logic                     valid_d;
    logic [NUM_INSTR-1:0]     aligned_d;
    logic [NUM_DATA_BITS-1:0] data_d;
    logic                     error_d;

    logic [NUM_INSTR-1:0]     extra_bits;
    logic [NUM_INSTR-1:0]     merged;

    // Slots presented that were never issued, and the completed set while holding
    assign extra_bits = delayed_instructions & ~orig_instructions;
    assign merged     = cap_part_q | delayed_instructions;

    // Next-state, capture and output decode
    always_comb begin
        state_d     = state_q;
        cap_instr_d = cap_instr_q;
        cap_part_d  = cap_part_q;
        cap_data_d  = cap_data_q;
        valid_d     = 1'b0;
        aligned_d   = '0;
        data_d      = '0;
        error_d     = error_q_dummy();

        unique case (state_q)
            IDLE: begin
                if ((delayed_instructions == orig_instructions) || (extra_bits != '0)) begin
                    // Whole set (or an illegal one, flagged but still passed through)
                    valid_d   = 1'b1;
                    aligned_d = orig_instructions;
                    data_d    = data_in;
                    if (extra_bits != '0) begin
                        error_d = 1'b1;
                    end
                end else begin
                    // Only part of the set arrived: park it and emit a bubble
                    cap_instr_d = orig_instructions;
                    cap_part_d  = delayed_instructions;
                    cap_data_d  = data_in;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                valid_d     = 1'b1;
                aligned_d   = merged;
                data_d      = cap_data_q;
                cap_instr_d = '0;
                cap_part_d  = '0;
                cap_data_d  = '0;
                state_d     = IDLE;
                // New issue during the wait, duplicated slots, or an incomplete set
                if ((orig_instructions != '0) ||
                    ((delayed_instructions & cap_part_q) != '0) ||
                    (merged != cap_instr_q)) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error is read back from the output register
    function automatic logic error_q_dummy();
        return error;
    endfunction

    // State, capture and registered outputs; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= IDLE;
            cap_instr_q          <= '0;
            cap_part_q           <= '0;
            cap_data_q           <= '0;
            aligned_valid        <= 1'b0;
            aligned_instructions <= '0;
            data_out             <= '0;
            error                <= 1'b0;
        end else begin
            state_q              <= state_d;
            cap_instr_q          <= cap_instr_d;
            cap_part_q           <= cap_part_d;
            cap_data_q           <= cap_data_d;
            aligned_valid        <= valid_d;
            aligned_instructions <= aligned_d;
            data_out             <= data_d;
            error                <= error_d;
        end
    end

    // Count follows the registered aligned set, so it is zero on bubbles
    count_ones #(
        .WIDTH    (NUM_INSTR),
        .CNT_WIDTH(CNTWIDTH)
    ) u_count_ones (
        .bits(aligned_instructions),
        .ones(count)
    );

endmodule

// File: tb/tb_instr_realign.sv
// Directed scoreboard bench for instr_realign with four instruction slots.
module tb_instr_realign;

    localparam int unsigned NI = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst;
    logic [NI-1:0] orig_instructions;
    logic [NI-1:0] delayed_instructions;
    logic [DW-1:0] data_in;
    logic          aligned_valid;
    logic [NI-1:0] aligned_instructions;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count;
    logic          error;

    typedef struct packed {
        logic          valid;
        logic [NI-1:0] aligned;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    instr_realign #(
        .NUM_INSTR    (NI),
        .NUM_DATA_BITS(DW),
        .CNTWIDTH     (CW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .orig_instructions   (orig_instructions),
        .delayed_instructions(delayed_instructions),
        .data_in             (data_in),
        .aligned_valid       (aligned_valid),
        .aligned_instructions(aligned_instructions),
        .data_out            (data_out),
        .count               (count),
        .error               (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One issue cycle: queue the expected result, drive, then compare one edge later
    task automatic step(input string name, input logic [NI-1:0] o, input logic [NI-1:0] d,
                        input logic [DW-1:0] din, input logic ev, input logic [NI-1:0] ea,
                        input logic [DW-1:0] ed, input logic ee);
        exp_t e;
        logic [CW-1:0] ec;
        e.valid = ev;
        e.aligned = ea;
        e.data = ed;
        e.err = ee;
        exp_q.push_back(e);
        orig_instructions    = o;
        delayed_instructions = d;
        data_in              = din;
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        ec = CW'($countones(e.aligned));
        checks++;
        if (aligned_valid !== e.valid) begin
            errors++;
            $display("FAIL %s valid: got %b expected %b", name, aligned_valid, e.valid);
        end
        checks++;
        if (aligned_instructions !== e.aligned) begin
            errors++;
            $display("FAIL %s aligned: got %b expected %b", name, aligned_instructions, e.aligned);
        end
        checks++;
        if (data_out !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, data_out, e.data);
        end
        checks++;
        if (count !== ec) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, count, ec);
        end
        checks++;
        if (error !== e.err) begin
            errors++;
            $display("FAIL %s error: got %b expected %b", name, error, e.err);
        end
    endtask

    // Assert reset away from a clock edge and confirm outputs clear without an edge
    task automatic apply_reset(input string name);
        rst = 1'b1;
        #1;
        checks++;
        if ({aligned_valid, aligned_instructions, data_out, count, error} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got v=%b a=%b d=%h c=%0d e=%b expected all zero", name,
                     aligned_valid, aligned_instructions, data_out, count, error);
        end
        orig_instructions    = '0;
        delayed_instructions = 4'b0010;
        data_in              = 64'hDEAD;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset("reset_init");
    endtask

    task automatic test_pass_through();
        step("pass_1011", 4'b1011, 4'b1011, 64'hA5, 1'b1, 4'b1011, 64'hA5, 1'b0);
        step("pass_zero", 4'b0000, 4'b0000, 64'h33, 1'b1, 4'b0000, 64'h33, 1'b0);
        step("pass_1111", 4'b1111, 4'b1111, 64'h0123_4567_89AB_CDEF, 1'b1, 4'b1111,
             64'h0123_4567_89AB_CDEF, 1'b0);
    endtask

    task automatic test_split();
        step("split_t", 4'b1011, 4'b1001, 64'h11, 1'b0, 4'b0000, 64'h0, 1'b0);
        step("split_t1", 4'b0000, 4'b0010, 64'h22, 1'b1, 4'b1011, 64'h11, 1'b0);
    endtask

    task automatic test_back_to_back();
        step("b2b_a0", 4'b1100, 4'b1000, 64'hC1, 1'b0, 4'b0000, 64'h0, 1'b0);
        step("b2b_a1", 4'b0000, 4'b0100, 64'hC2, 1'b1, 4'b1100, 64'hC1, 1'b0);
        step("b2b_b0", 4'b0011, 4'b0001, 64'hD1, 1'b0, 4'b0000, 64'h0, 1'b0);
        step("b2b_b1", 4'b0000, 4'b0010, 64'hD2, 1'b1, 4'b0011, 64'hD1, 1'b0);
        step("b2b_pass", 4'b0101, 4'b0101, 64'hE0, 1'b1, 4'b0101, 64'hE0, 1'b0);
    endtask

    task automatic test_duplicate();
        step("dup_t", 4'b1011, 4'b1001, 64'h11, 1'b0, 4'b0000, 64'h0, 1'b0);
        step("dup_t1", 4'b0000, 4'b1010, 64'h22, 1'b1, 4'b1011, 64'h11, 1'b1);
        step("dup_sticky", 4'b0001, 4'b0001, 64'h44, 1'b1, 4'b0001, 64'h44, 1'b1);
    endtask

    task automatic test_orig_in_hold();
        apply_reset("reset_pre_orig");
        step("oih_t", 4'b1011, 4'b1001, 64'h55, 1'b0, 4'b0000, 64'h0, 1'b0);
        step("oih_t1", 4'b0100, 4'b0010, 64'h66, 1'b1, 4'b1011, 64'h55, 1'b1);
        step("oih_after", 4'b0000, 4'b0000, 64'h77, 1'b1, 4'b0000, 64'h77, 1'b1);
    endtask

    task automatic test_illegal_idle();
        apply_reset("reset_pre_illegal");
        step("ill_idle", 4'b0010, 4'b0110, 64'h88, 1'b1, 4'b0010, 64'h88, 1'b1);
        step("ill_cont", 4'b1000, 4'b1000, 64'h89, 1'b1, 4'b1000, 64'h89, 1'b1);
    endtask

    task automatic test_reset_mid_hold();
        step("rmh_pass", 4'b1111, 4'b1111, 64'hF0, 1'b1, 4'b1111, 64'hF0, 1'b1);
        step("rmh_split", 4'b1011, 4'b1001, 64'h99, 1'b0, 4'b0000, 64'h0, 1'b1);
        apply_reset("reset_mid_hold");
        step("rmh_fresh", 4'b0001, 4'b0001, 64'hAB, 1'b1, 4'b0001, 64'hAB, 1'b0);
        step("rmh_next", 4'b0000, 4'b0000, 64'hAC, 1'b1, 4'b0000, 64'hAC, 1'b0);
    endtask

    initial begin
        rst                  = 1'b1;
        orig_instructions    = '0;
        delayed_instructions = '0;
        data_in              = '0;
        #2;
        test_reset();
        test_pass_through();
        test_split();
        test_back_to_back();
        test_duplicate();
        test_orig_in_hold();
        test_illegal_idle();
        test_reset_mid_hold();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
